pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
Hazard and sequencing controller for the 5-stage pipeline (F, D, E, M, W). It generates stall, flush and forwarding controls around the execute stage, where the conditional unit resolves PCSrc, RegWrite and MemWrite. It also sequences multi-cycle data-memory accesses through a wait/timeout state machine. It sits beside the pipeline registers and drives their enable and clear pins.

Parameters:
REG_ADDR_W, 4, register-file address width
MEM_TIMEOUT, 64, maximum wait cycles for mem_ready before the error state
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
RA1D  in  REG_ADDR_W  source reg 1 in decode
RA2D  in  REG_ADDR_W  source reg 2 in decode
RA1E  in  REG_ADDR_W  source reg 1 in execute
RA2E  in  REG_ADDR_W  source reg 2 in execute
WA3E  in  REG_ADDR_W  destination reg in execute
MemtoRegE  in  1  execute instruction is a load
WA3M  in  REG_ADDR_W  destination reg in memory stage
RegWriteM  in  1  memory-stage instruction writes the register file
WA3W  in  REG_ADDR_W  destination reg in writeback
RegWriteW  in  1  writeback instruction writes the register file
PCSrcE  in  1  taken branch / PC write from conditional unit, execute stage
mem_req_M  in  1  memory-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
FlushW  out  1  clear M/W register (bubble)
ForwardAE  out  2  ALU operand A select: 00 regfile, 01 W result, 10 M result
ForwardBE  out  2  ALU operand B select, same encoding
mem_error  out  1  memory timeout, sticky
stall_count  out  CNT_W  cycles with StallF=1, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, wait counter=0, stall_count=0, mem_error=0. All stall and flush outputs are 0 while in reset. ForwardAE and ForwardBE stay combinational.
- Forwarding (combinational, in every state):
  - ForwardAE=10 if RegWriteM && WA3M==RA1E.
  - Otherwise ForwardAE=01 if RegWriteW && WA3W==RA1E.
  - Otherwise ForwardAE=00.
  - ForwardBE follows the same rules with RA2E.
  - M has priority over W.
- FSM states: RUN, MEM_WAIT, ERROR. All stall/flush outputs are combinational from the current state and current inputs.
- RUN, evaluated in priority order:
  - (1) mem_req_M && !mem_ready: memory stall. StallF=StallD=StallE=StallM=1, FlushW=1. Next state MEM_WAIT, wait counter loads 1.
  - (2) Otherwise PCSrcE=1: FlushD=FlushE=1, no stalls.
  - (3) Otherwise load-use, i.e. MemtoRegE && (WA3E==RA1D || WA3E==RA2D): StallF=StallD=1, FlushE=1.
  - (4) Otherwise all 0.
  - A single-cycle access (mem_req_M && mem_ready) causes no stall.
- MEM_WAIT:
  - While mem_ready=0: all four stalls and FlushW=1, FlushD=FlushE=0; branch and load-use are not acted on. Wait counter increments. When the counter equals MEM_TIMEOUT with mem_ready=0, next state is ERROR.
  - Release cycle (mem_ready=1): stalls deassert and FlushW=0. Branch/load-use evaluate as in RUN items (2)-(3) in the same cycle. A PCSrcE held in E during the wait therefore flushes on the release cycle. Next state RUN, counter cleared.
- ERROR: StallF=StallD=StallE=StallM=1, FlushW=1, mem_error=1. Exited only by reset.
- stall_count increments on every rising edge where StallF=1 and saturates at 2^CNT_W-1.
- A reset asserted mid-wait returns to RUN immediately and clears all counters.

Test Plan:
- Forwarding:
  - RegWriteM=1, WA3M=5, RegWriteW=1, WA3W=5, RA1E=5, RA2E=3 -> ForwardAE=10, ForwardBE=00.
  - Then RegWriteM=0 -> ForwardAE=01.
- Load-use: MemtoRegE=1, WA3E=2, RA2D=2 -> one cycle of StallF=StallD=FlushE=1. The next cycle with MemtoRegE=0 -> all 0. stall_count=1.
- Branch flush: PCSrcE=1, no memory request -> FlushD=FlushE=1, StallF=0. Branch with a simultaneous load-use -> FlushD=FlushE=1 and StallF=0 (branch wins).
- Memory wait:
  - mem_req_M=1, mem_ready=0 for 3 cycles, then 1 -> stalls and FlushW=1 for 3 cycles.
  - Release cycle all 0; state returns to RUN; stall_count=3.
  - With PCSrcE=1 held throughout -> FlushD=FlushE=1 only on the release cycle.
- Timeout: mem_ready held 0 with MEM_TIMEOUT=4 -> ERROR after 4 wait cycles, mem_error=1 and stalls held. Asserting rst=0 -> mem_error=0, stalls=0, stall_count=0 asynchronously.
- Reset mid-wait: rst=0 during the second MEM_WAIT cycle -> outputs drop without a clock edge. After rst=1 with mem_req_M=0 -> RUN, no stalls.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for a 5-stage pipeline: operand forwarding into E,
// load-use and branch handling, and a wait/timeout sequencer for slow data-memory accesses.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] RA1E,
  input  logic [REG_ADDR_W-1:0] RA2E,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic                  MemtoRegE,
  input  logic [REG_ADDR_W-1:0] WA3M,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  mem_req_M,
  input  logic                  mem_ready,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  mem_error,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic mem_stall;
  logic load_use;
  logic stall_all;
  logic stall_fd;
  logic flush_d;
  logic flush_e;

  // Forwarding: the newer result in M takes priority over the one in W.
  function automatic fwd_e fwd_sel(input logic [REG_ADDR_W-1:0] ra);
    if (RegWriteM && (WA3M == ra))      return FWD_M;
    else if (RegWriteW && (WA3W == ra)) return FWD_W;
    else                                return FWD_RF;
  endfunction

  assign ForwardAE = fwd_sel(RA1E);
  assign ForwardBE = fwd_sel(RA2E);

  assign mem_stall = mem_req_M && !mem_ready;
  assign load_use  = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_all  = 1'b0;
    stall_fd   = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          stall_all  = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_fd = 1'b1;
          flush_e  = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          stall_all = 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Release cycle: a branch or load-use held in E/D during the wait acts now.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (load_use) begin
            stall_fd = 1'b1;
            flush_e  = 1'b1;
          end
        end
      end

      ST_ERROR: begin
        stall_all = 1'b1;
      end

      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline-register controls are forced inactive while reset is held.
  assign StallF = rst && (stall_all || stall_fd);
  assign StallD = rst && (stall_all || stall_fd);
  assign StallE = rst && stall_all;
  assign StallM = rst && stall_all;
  assign FlushD = rst && flush_d;
  assign FlushE = rst && flush_e;
  assign FlushW = rst && stall_all;

  always_comb begin
    stall_count_d = stall_count_q;
    if (StallF && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_error   = (state_q == ST_ERROR);
  assign stall_count = stall_count_q;

endmodule
